// File: rtl/fc_dense_classifier.sv
// Sequential fully-connected output layer: MACs the latched pooled map against
// ROM weights/biases for each class, saturates the scores, then picks the argmax.
module fc_dense_classifier #(
  parameter int IN_H  = 14,
  parameter int IN_W  = 14,
  parameter int N_OUT = 10,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  localparam int N  = IN_H * IN_W,
  localparam int AW = $clog2(N_OUT * (N + 1)),
  localparam int CW = $clog2(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [15:0]  in_map [0:IN_H-1][0:IN_W-1],
  output logic [AW-1:0]       w_addr,
  input  logic signed [15:0]  w_data,
  output logic                busy,
  output logic                done,
  output logic signed [15:0]  score [0:N_OUT-1],
  output logic [CW-1:0]       class_idx
);

  localparam int KW  = $clog2(N + 1);
  localparam int RW  = $clog2(IN_H);
  localparam int CLW = $clog2(IN_W);

  localparam logic [KW-1:0]  K_LAST = KW'(N);
  localparam logic [CW-1:0]  O_LAST = CW'(N_OUT - 1);
  localparam logic [CLW-1:0] C_LAST = CLW'(IN_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_STORE,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [15:0]      map_q [0:IN_H-1][0:IN_W-1];
  logic [KW-1:0]           cnt;
  logic [RW-1:0]           row;
  logic [CLW-1:0]          col;
  logic [CW-1:0]           o_idx;
  logic [CW-1:0]           a_idx;
  logic [CW-1:0]           best_idx;
  logic signed [15:0]      best;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] res_q;

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] acc_b;
  logic signed [ACC_W-1:0] res_d;
  logic signed [15:0]      sat;
  logic                    take;
  logic signed [15:0]      best_nx;
  logic [CW-1:0]           idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_MAC;
      end
      S_MAC:    if (cnt == K_LAST) state_d = S_BIAS;
      S_BIAS:   state_d = S_STORE;
      S_STORE:  state_d = (o_idx == O_LAST) ? S_ARGMAX : S_MAC;
      S_ARGMAX: if (a_idx == O_LAST) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod    = map_q[row][col] * w_data;
    acc_b   = acc + (ACC_W'(w_data) <<< FRAC);
    res_d   = acc_b >>> FRAC;
    if (res_q > SAT_HI)      sat = 16'sh7fff;
    else if (res_q < SAT_LO) sat = 16'sh8000;
    else                     sat = res_q[15:0];
    take    = (a_idx == '0) || (score[a_idx] > best);
    best_nx = take ? score[a_idx] : best;
    idx_nx  = take ? a_idx : best_idx;
  end

  // w_addr walks the ROM contiguously: each MAC cycle issues the next word and
  // the weight arriving in that cycle belongs to the previous address (row/col).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q     <= '{default: '{default: '0}};
      score     <= '{default: '0};
      class_idx <= '0;
      w_addr    <= '0;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      o_idx     <= '0;
      a_idx     <= '0;
      best_idx  <= '0;
      best      <= '0;
      acc       <= '0;
      res_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            map_q  <= in_map;
            score  <= '{default: '0};
            o_idx  <= '0;
            cnt    <= '0;
            w_addr <= '0;
          end
        end
        S_MAC: begin
          if (cnt == '0) begin
            acc <= '0;
            row <= '0;
            col <= '0;
          end else begin
            acc <= acc + ACC_W'(prod);
            if (col == C_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          if (cnt != K_LAST) begin
            cnt    <= cnt + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        S_BIAS: res_q <= res_d;
        S_STORE: begin
          score[o_idx] <= sat;
          cnt          <= '0;
          if (o_idx != O_LAST) begin
            o_idx  <= o_idx + 1'b1;
            w_addr <= w_addr + 1'b1;
          end else begin
            a_idx <= '0;
          end
        end
        S_ARGMAX: begin
          best     <= best_nx;
          best_idx <= idx_nx;
          a_idx    <= a_idx + 1'b1;
          if (a_idx == O_LAST) class_idx <= idx_nx;
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_dense_classifier.sv
// Bench for fc_dense_classifier: behavioural weight ROM, table of classification
// vectors with a result scoreboard, plus restart/reset/idle corner sequences.
module tb_fc_dense_classifier;

  localparam int IN_H  = 14;
  localparam int IN_W  = 14;
  localparam int N_OUT = 10;
  localparam int N     = IN_H * IN_W;
  localparam int NW    = N_OUT * (N + 1);
  localparam int LAT   = 2001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] in_map [0:IN_H-1][0:IN_W-1];
  logic [10:0]        w_addr;
  logic signed [15:0] w_data = '0;
  logic               busy;
  logic               done;
  logic signed [15:0] score [0:N_OUT-1];
  logic [3:0]         class_idx;

  logic signed [15:0] rom [0:NW-1];

  fc_dense_classifier #(.IN_H(IN_H), .IN_W(IN_W), .N_OUT(N_OUT), .FRAC(8), .ACC_W(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_map    (in_map),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .score     (score),
    .class_idx (class_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  int cyc = 0;
  int dcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) dcnt <= dcnt + 1;

  // map_fill everywhere, optional single pixel; weights w_fill (all outputs or
  // only w_out), optional single special weight; bias of output o = o*bias_step.
  // Expected score[o] = e_base + o*e_step, except e_ex_o which gets e_ex_v.
  typedef struct packed {
    int map_fill; int pix_idx; int pix_val;
    int w_fill;   int w_out;
    int sp_out;   int sp_idx;  int sp_val;
    int bias_step;
    int e_base;   int e_step;  int e_ex_o; int e_ex_v; int e_cls;
  } vec_t;

  typedef struct packed {
    logic [N_OUT-1:0][15:0] sc;
    int                     cls;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];

  int ncmp = 0;
  int nfail = 0;
  int t0 = 0;

  task automatic check(input string nm, input int act, input int req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        in_map[r][c] = (r * IN_W + c == v.pix_idx) ? 16'(v.pix_val) : 16'(v.map_fill);
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k < N; k++)
        rom[o * (N + 1) + k] = (v.w_out < 0 || v.w_out == o) ? 16'(v.w_fill) : 16'sd0;
      rom[o * (N + 1) + N] = 16'(o * v.bias_step);
    end
    if (v.sp_out >= 0) rom[v.sp_out * (N + 1) + v.sp_idx] = 16'(v.sp_val);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    for (int o = 0; o < N_OUT; o++)
      e.sc[o] = (o == v.e_ex_o) ? 16'(v.e_ex_v) : 16'(v.e_base + o * v.e_step);
    e.cls = v.e_cls;
    sbq.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2500 && !ok; i++) begin
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic compare_results(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, " scoreboard_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    check({tag, " latency"}, cyc - t0, LAT);
    check({tag, " busy_at_done"}, int'(busy), 1);
    for (int o = 0; o < N_OUT; o++)
      check($sformatf("%s score[%0d]", tag, o), int'(score[o]), int'($signed(e.sc[o])));
    check({tag, " class_idx"}, int'(class_idx), e.cls);
  endtask

  task automatic finish_run(input string tag);
    bit ok;
    wait_done(ok);
    if (ok) begin
      compare_results(tag);
      @(negedge clk);
      check({tag, " done_pulse_width"}, int'(done), 0);
      check({tag, " busy_after_done"}, int'(busy), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0;
    //         map  pix  pv  wf  wo  so  si   sv   bias  base    step e_o  e_v    cls
    vecs[0] = '{0,    -1, 0,   0,  -1, -1, 0,  0,    256, 0,      256, -1, 0,     9};
    vecs[1] = '{256,  -1, 0,   256, 3, -1, 0,  0,    0,   0,      0,   3,  32767, 3};
    vecs[2] = '{-256, -1, 0,   256, -1, -1, 0, 0,    0,   -32768, 0,   -1, 0,     0};
    vecs[3] = '{0,    77, 128, 0,  -1, 6,  77, -512, 0,   0,      0,   6,  -256,  0};
    vecs[4] = '{-1,   -1, 0,   1,  -1, -1, 0,  0,    0,   -1,     0,   -1, 0,     0};
    vecs[5] = '{256,  -1, 0,   1,  -1, -1, 0,  0,    256, 196,    256, -1, 0,     9};
    vecs[6] = '{256,  -1, 0,   0,  -1, 4,  0,  512,  0,   0,      0,   4,  512,   4};

    load_vec(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset w_addr", int'(w_addr), 0);
    check("reset class_idx", int'(class_idx), 0);
    check("reset score[0]", int'(score[0]), 0);
    check("reset score[9]", int'(score[9]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      load_vec(vecs[i]);
      push_exp(vecs[i]);
      pulse_start();
      finish_run($sformatf("vec%0d", i));
    end

    // results and address hold while idle
    repeat (5) @(negedge clk);
    check("idle hold class_idx", int'(class_idx), 4);
    check("idle hold score[4]", int'(score[4]), 512);
    check("idle hold w_addr", int'(w_addr), NW - 1);
    check("idle busy", int'(busy), 0);

    // asynchronous reset mid-run
    load_vec(vecs[5]);
    push_exp(vecs[5]);
    pulse_start();
    repeat (1000) @(negedge clk);
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset class_idx", int'(class_idx), 0);
    check("midreset w_addr", int'(w_addr), 0);
    check("midreset score[9]", int'(score[9]), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1100) @(negedge clk);
    check("midreset no_done", dcnt - d0, 0);
    push_exp(vecs[5]);
    pulse_start();
    finish_run("after_reset");

    // start while busy is ignored, even with a changed map
    load_vec(vecs[1]);
    push_exp(vecs[1]);
    d0 = dcnt;
    pulse_start();
    repeat (50) @(negedge clk);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        in_map[r][c] = -16'sd256;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("busy_start");
    repeat (20) @(negedge clk);
    check("busy_start done_count", dcnt - d0, 1);

    // start during done ignored; start on the next idle cycle accepted
    load_vec(vecs[3]);
    push_exp(vecs[3]);
    pulse_start();
    wait_done(ok);
    if (ok) begin
      compare_results("done_start");
      start = 1'b1;
      @(negedge clk);
      check("done_start busy_idle", int'(busy), 0);
      t0 = cyc;
      push_exp(vecs[3]);
      @(negedge clk);
      start = 1'b0;
      check("done_start accepted", int'(busy), 1);
      finish_run("done_start_rerun");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
